// File: rtl/l0_stagger_fifo_if.sv
// Handshake/data bundle for the L0 staggered input FIFO.
// Optional o_err exists only when L0_ERR_FLAG_EN is defined.
interface l0_stagger_fifo_if #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
);
  localparam int CW = $clog2(depth) + 1;

  logic [row*bw-1:0] in;
  logic              wr;
  logic              rd;
  logic              mode;
  logic [row*bw-1:0] out;
  logic [row-1:0]    o_valid;
  logic              o_full;
  logic              o_afull;
  logic              o_ready;
  logic              o_empty;
  logic [CW-1:0]     o_count;
`ifdef L0_ERR_FLAG_EN
  logic              o_err;
`endif

  modport master (
    output in, wr, rd, mode,
    input  out, o_valid, o_full, o_afull,
    input  o_ready, o_empty, o_count
`ifdef L0_ERR_FLAG_EN
    , input o_err
`endif
  );

  modport slave (
    input  in, wr, rd, mode,
    output out, o_valid, o_full, o_afull,
    output o_ready, o_empty, o_count
`ifdef L0_ERR_FLAG_EN
    , output o_err
`endif
  );
endinterface

// File: rtl/l0_stagger_fifo.sv
// L0 systolic input buffer: row lanes of bw-bit FIFOs, skewed or broadcast read.
// Define L0_ERR_FLAG_EN to add the sticky overflow/underflow flag o_err.
module l0_stagger_fifo #(
  parameter int row      = 8,
  parameter int bw       = 4,
  parameter int depth    = 64,
  parameter int afull_th = 60
) (
  input logic           clk,
  input logic           reset,
  l0_stagger_fifo_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [bw-1:0]     mem  [row][depth];
  logic [AW-1:0]     wptr [row];
  logic [AW-1:0]     rptr [row];
  logic [CW-1:0]     cnt  [row];
  logic [row-1:0]    rd_en;
  logic [row-1:0]    full_v;
  logic [row-1:0]    afull_v;
  logic [row-1:0]    empty_v;
  logic [row-1:0]    do_rd;
  logic              do_wr;
  logic [row*bw-1:0] out_q;
  logic [row-1:0]    valid_q;

  always_comb begin
    full_v  = '0;
    afull_v = '0;
    empty_v = '0;
    for (int i = 0; i < row; i++) begin
      full_v[i]  = (cnt[i] == CW'(depth));
      afull_v[i] = (cnt[i] >= CW'(afull_th));
      empty_v[i] = (cnt[i] == '0);
    end
  end

  // full/empty come from the pre-update counts: no write-at-full, no bypass
  assign do_wr = bus.wr && !(|full_v);
  assign do_rd = rd_en & ~empty_v;

  assign bus.o_full  = |full_v;
  assign bus.o_afull = |afull_v;
  assign bus.o_ready = ~(|full_v);
  assign bus.o_empty = &empty_v;
  assign bus.o_count = cnt[0];
  assign bus.out     = out_q;
  assign bus.o_valid = valid_q;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < row; i++) begin
        mem[i][wptr[i]] <= bus.in[i*bw +: bw];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= '0;
      out_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < row; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (bus.mode) begin
        rd_en <= {row{bus.rd}};
      end else begin
        rd_en <= {rd_en[row-2:0], bus.rd};
      end
      valid_q <= do_rd;
      for (int i = 0; i < row; i++) begin
        if (do_wr) begin
          wptr[i] <= wptr[i] + 1'b1;
        end
        if (do_rd[i]) begin
          out_q[i*bw +: bw] <= mem[i][rptr[i]];
          rptr[i]           <= rptr[i] + 1'b1;
        end
        cnt[i] <= cnt[i] + CW'(do_wr) - CW'(do_rd[i]);
      end
    end
  end

`ifdef L0_ERR_FLAG_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((bus.wr && |full_v) || |(rd_en & empty_v)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`endif

endmodule

// File: tb/tb_l0_stagger_fifo.sv
// Randomized + directed bench for l0_stagger_fifo against a queue-based lane model.
module tb_l0_stagger_fifo;
  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;
  localparam int AFULL = 60;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  l0_stagger_fifo_if #(.row(ROW), .bw(BW), .depth(DEPTH)) bus ();

  l0_stagger_fifo #(
    .row(ROW), .bw(BW), .depth(DEPTH), .afull_th(AFULL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model: each lane is a queue; a rd captured at edge e attempts a pop on
  // lane i at edge e+1+i (staggered) or e+1 on every lane (broadcast).
  logic [BW-1:0]     q [ROW][$];
  logic [ROW-1:0]    pend [32];
  logic [ROW*BW-1:0] exp_out;
  logic [ROW-1:0]    exp_valid;
  logic              exp_err;
  logic [ROW-1:0]    att;
  logic              full_b;
  logic              armed = 1'b0;
  int                cyc = 0;
  int                m_full, m_afull, m_empty;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROW; i++) q[i].delete();
      for (int p = 0; p < 32; p++) pend[p] = '0;
      exp_out   = '0;
      exp_valid = '0;
      exp_err   = 1'b0;
      armed     = 1'b1;
    end else if (armed) begin
      att = pend[cyc % 32];
      pend[cyc % 32] = '0;
      full_b = 1'b0;
      for (int i = 0; i < ROW; i++)
        if (q[i].size() == DEPTH) full_b = 1'b1;
      for (int i = 0; i < ROW; i++) begin
        if (att[i] && q[i].size() > 0) begin
          exp_out[i*BW +: BW] = q[i].pop_front();
          exp_valid[i] = 1'b1;
        end else begin
          exp_valid[i] = 1'b0;
          if (att[i]) exp_err = 1'b1;
        end
      end
      if (bus.wr && full_b) exp_err = 1'b1;
      if (bus.wr && !full_b)
        for (int i = 0; i < ROW; i++) q[i].push_back(bus.in[i*BW +: BW]);
      if (bus.rd) begin
        if (bus.mode) pend[(cyc + 1) % 32] = '1;
        else
          for (int i = 0; i < ROW; i++) pend[(cyc + 1 + i) % 32][i] = 1'b1;
      end
    end
    cyc++;
    #1;
    if (armed) begin
      m_full  = 0;
      m_afull = 0;
      m_empty = 1;
      for (int i = 0; i < ROW; i++) begin
        if (q[i].size() == DEPTH) m_full = 1;
        if (q[i].size() >= AFULL) m_afull = 1;
        if (q[i].size() != 0) m_empty = 0;
      end
      check("out", 64'(bus.out), 64'(exp_out));
      check("o_valid", 64'(bus.o_valid), 64'(exp_valid));
      check("o_count", 64'(bus.o_count), 64'(q[0].size()));
      check("o_full", 64'(bus.o_full), 64'(m_full));
      check("o_afull", 64'(bus.o_afull), 64'(m_afull));
      check("o_ready", 64'(bus.o_ready), 64'(1 - m_full));
      check("o_empty", 64'(bus.o_empty), 64'(m_empty));
`ifdef L0_ERR_FLAG_EN
      check("o_err", 64'(bus.o_err), 64'(exp_err));
`endif
    end
  end

  task automatic flush();
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    repeat (ROW + 1) tick();
  endtask

  logic [3:0] lane;
  logic [7:0] exp_v;
  int         wr_pct, rd_pct;

  initial begin
    bus.in   = '0;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    bus.mode = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    check("rst_empty", 64'(bus.o_empty), 64'd1);
    check("rst_full", 64'(bus.o_full), 64'd0);
    check("rst_afull", 64'(bus.o_afull), 64'd0);
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_count", 64'(bus.o_count), 64'd0);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    reset = 1'b0;
    tick();

    // staggered single read
    bus.in = 32'h76543210;
    bus.wr = 1'b1;
    tick();
    bus.wr   = 1'b0;
    bus.mode = 1'b0;
    bus.rd   = 1'b1;
    tick();
    bus.rd = 1'b0;
    for (int j = 1; j <= ROW + 2; j++) begin
      exp_v = (j >= 2 && j - 2 < ROW) ? 8'(1 << (j - 2)) : 8'h00;
      check("stag_valid", 64'(bus.o_valid), 64'(exp_v));
      if (exp_v != 0) begin
        lane = 4'(bus.out >> ((j - 2) * BW));
        check("stag_lane", 64'(lane), 64'(j - 2));
      end
      if (j == 1) check("stag_cnt1", 64'(bus.o_count), 64'd1);
      if (j == 2) check("stag_cnt0", 64'(bus.o_count), 64'd0);
      tick();
    end
    flush();

    // broadcast two-word read
    bus.in = 32'h76543210;
    bus.wr = 1'b1;
    tick();
    bus.in = 32'hFEDCBA98;
    tick();
    bus.wr   = 1'b0;
    bus.mode = 1'b1;
    bus.rd   = 1'b1;
    tick();
    check("bc_j1", 64'(bus.o_valid), 64'h00);
    tick();
    bus.rd = 1'b0;
    check("bc_v0", 64'(bus.o_valid), 64'hFF);
    check("bc_d0", 64'(bus.out), 64'h76543210);
    tick();
    check("bc_v1", 64'(bus.o_valid), 64'hFF);
    check("bc_d1", 64'(bus.out), 64'hFEDCBA98);
    tick();
    check("bc_v2", 64'(bus.o_valid), 64'h00);
    check("bc_empty", 64'(bus.o_empty), 64'd1);
    flush();

    // fill to almost-full, full, then overflow
    bus.wr = 1'b1;
    for (int k = 0; k < AFULL; k++) begin
      bus.in = $urandom;
      tick();
    end
    check("af_afull", 64'(bus.o_afull), 64'd1);
    check("af_full", 64'(bus.o_full), 64'd0);
    for (int k = AFULL; k < DEPTH; k++) begin
      bus.in = $urandom;
      tick();
    end
    check("f_full", 64'(bus.o_full), 64'd1);
    check("f_ready", 64'(bus.o_ready), 64'd0);
    check("f_count", 64'(bus.o_count), 64'd64);
    bus.in = 32'hDEADBEEF;
    tick();
    check("ovf_count", 64'(bus.o_count), 64'd64);
    bus.wr   = 1'b0;
    bus.mode = 1'b1;
    bus.rd   = 1'b1;
    tick();
    bus.rd = 1'b0;
    bus.wr = 1'b1;
    tick();
    bus.wr = 1'b0;
    check("wr_rd_full", 64'(bus.o_count), 64'd63);
`ifdef L0_ERR_FLAG_EN
    check("err_ovf", 64'(bus.o_err), 64'd1);
`endif
    bus.rd = 1'b1;
    repeat (DEPTH) tick();
    bus.rd = 1'b0;
    tick();
    check("drain_cnt", 64'(bus.o_count), 64'd0);
    flush();

    // wrap-around with staggered reads
    bus.mode = 1'b0;
    bus.wr   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in = $urandom;
      tick();
    end
    bus.wr = 1'b0;
    bus.rd = 1'b1;
    repeat (10) tick();
    flush();
    check("wrap_cnt", 64'(bus.o_count), 64'd0);

    // reads on empty lanes
    bus.mode = 1'b1;
    bus.rd   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("emp_valid", 64'(bus.o_valid), 64'd0);
      check("emp_cnt", 64'(bus.o_count), 64'd0);
    end
    flush();

    // reset mid staggered drain
    bus.mode = 1'b0;
    bus.wr   = 1'b1;
    repeat (3) begin
      bus.in = $urandom;
      tick();
    end
    bus.wr = 1'b0;
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_v", 64'(bus.o_valid), 64'd0);
    check("rst_mid_c", 64'(bus.o_count), 64'd0);
`ifdef L0_ERR_FLAG_EN
    check("rst_mid_e", 64'(bus.o_err), 64'd0);
`endif
    tick();
    check("rst_mid_v2", 64'(bus.o_valid), 64'd0);

    // randomized blocks; mode only changes once rd_en has drained
    for (int b = 0; b < 30; b++) begin
      bus.mode = 1'($urandom);
      wr_pct   = $urandom_range(10, 95);
      rd_pct   = $urandom_range(5, 90);
      for (int c = 0; c < 60; c++) begin
        bus.in = $urandom;
        bus.wr = ($urandom_range(0, 99) < wr_pct);
        bus.rd = ($urandom_range(0, 99) < rd_pct);
        tick();
      end
      flush();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
